// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the MIPS pipeline datapath and the hazard sequencer.
// The datapath side is the master; hazard_ctrl consumes it through the slave modport.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      id_instru;
  logic [31:0]      ex_instru;
  logic [31:0]      ex_mem_instru;
  logic             c_ex_RegWrite;
  logic             c_ex_MemRead;
  logic             c_ex_mem_RegWrite;
  logic             c_ex_mem_MemRead;
  logic             branch_taken;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_instru, ex_instru, ex_mem_instru,
    output c_ex_RegWrite, c_ex_MemRead, c_ex_mem_RegWrite, c_ex_mem_MemRead,
    output branch_taken,
    input  pc_write, if_id_write, id_ex_bubble, if_id_flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_instru, ex_instru, ex_mem_instru,
    input  c_ex_RegWrite, c_ex_MemRead, c_ex_mem_RegWrite, c_ex_mem_MemRead,
    input  branch_taken,
    output pc_write, if_id_write, id_ex_bubble, if_id_flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// ID-stage hazard sequencer: load-use and ID-branch stalls, IF/ID flush on taken
// branch or jump, a RUN/HOLD FSM for two-cycle stalls, and saturating perf counters.
module hazard_ctrl #(
  parameter int         CNT_W  = 16,
  parameter logic [5:0] OP_LW  = 6'h23,
  parameter logic [5:0] OP_SW  = 6'h2B,
  parameter logic [5:0] OP_BEQ = 6'h04,
  parameter logic [5:0] OP_BNE = 6'h05,
  parameter logic [5:0] OP_J   = 6'h02
) (
  input  logic           clk,
  input  logic           rst_n,
  hazard_ctrl_if.slave   hz
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [1:0]       need;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  function automatic logic [4:0] dest_of(input logic [31:0] ins);
    return (ins[31:26] == 6'h00) ? ins[15:11] : ins[20:16];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [5:0] id_op;
  logic [4:0] id_rs, id_rt, ex_dest, exm_dest;
  logic       rt_src, is_br, ex_hit, exm_hit;

  assign id_op    = hz.id_instru[31:26];
  assign id_rs    = hz.id_instru[25:21];
  assign id_rt    = hz.id_instru[20:16];
  assign ex_dest  = dest_of(hz.ex_instru);
  assign exm_dest = dest_of(hz.ex_mem_instru);
  assign rt_src   = (id_op == 6'h00) || (id_op == OP_SW) || (id_op == OP_BEQ) || (id_op == OP_BNE);
  assign is_br    = (id_op == OP_BEQ) || (id_op == OP_BNE);
  assign ex_hit   = (ex_dest != 5'd0) && ((ex_dest == id_rs) || (rt_src && ex_dest == id_rt));
  assign exm_hit  = (exm_dest != 5'd0) && ((exm_dest == id_rs) || (rt_src && exm_dest == id_rt));

  // Fields irrelevant to hazard detection; gathered so they are visibly consumed.
  logic unused_bits;
  assign unused_bits = ^{OP_LW, hz.id_instru[15:0], hz.ex_instru[25:21], hz.ex_instru[10:0],
                         hz.ex_mem_instru[25:21], hz.ex_mem_instru[10:0]};

  always_comb begin
    need = 2'd0;
    if (is_br && hz.c_ex_RegWrite && ex_hit && hz.c_ex_MemRead)
      need = 2'd2;
    else if ((hz.c_ex_MemRead && ex_hit) ||
             (is_br && hz.c_ex_RegWrite && ex_hit) ||
             (is_br && hz.c_ex_mem_MemRead && hz.c_ex_mem_RegWrite && exm_hit))
      need = 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      rem_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      RUN: begin
        if (need == 2'd2) begin
          state_d = HOLD;
          rem_d   = 2'd1;
        end
      end
      HOLD: begin
        rem_d = rem_q - 2'd1;
        if (rem_q == 2'd1) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs are forced to free-running values while reset is held.
  always_comb begin
    stall = 1'b0;
    if (rst_n) stall = (state_q == HOLD) || (need != 2'd0);
  end

  assign hz.pc_write     = ~stall;
  assign hz.if_id_write  = ~stall;
  assign hz.id_ex_bubble = stall;
  assign hz.if_id_flush  = rst_n && !stall && (hz.branch_taken || id_op == OP_J);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall)          stall_cnt_q <= sat_inc(stall_cnt_q);
      if (hz.if_id_flush) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule
